// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: write-side buffer in front of the 8-entry register file.
// It queues ALU and load results in a circular FIFO and drains one entry per
// cycle into the register file write port. It also offers a two-port lookup
// of pending writes so decode can detect RAW hazards and forward data.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   alu_valid/reg/data/ready ALU result handshake
//   mem_valid/reg/data/ready load result handshake (older than a same-cycle ALU)
//   wb_stall                 hold the queue head; no write this cycle
//   RegWriteEn/WriteReg/WriteData  register file write port (from the head)
//   look_reg1/2 -> look_busy1/2, look_data1/2  pending-write lookup
//   count                    occupied entries
module reg_writeback_queue #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [ADDR_W-1:0]            alu_reg,
  input  logic [DATA_W-1:0]            alu_data,
  output logic                         alu_ready,
  input  logic                         mem_valid,
  input  logic [ADDR_W-1:0]            mem_reg,
  input  logic [DATA_W-1:0]            mem_data,
  output logic                         mem_ready,
  input  logic                         wb_stall,
  output logic                         RegWriteEn,
  output logic [ADDR_W-1:0]            WriteReg,
  output logic [DATA_W-1:0]            WriteData,
  input  logic [ADDR_W-1:0]            look_reg1,
  input  logic [ADDR_W-1:0]            look_reg2,
  output logic                         look_busy1,
  output logic                         look_busy2,
  output logic [DATA_W-1:0]            look_data1,
  output logic [DATA_W-1:0]            look_data2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Queue state
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [ADDR_W-1:0] ent_reg_q  [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];

  // Per-cycle control
  logic [CNT_W-1:0]  free_c;
  logic              mem_acc, alu_acc;
  logic              mem_push, alu_push;
  logic              pop;
  logic              empty;
  logic [PTR_W-1:0]  alu_slot;
  logic [PTR_W-1:0]  slot_idx [DEPTH];

  assign empty = (count_q == '0);
  assign count = count_q;

  // Ready uses occupancy before any same-cycle pop, so a full queue never
  // accepts even while it drains.
  always_comb begin
    free_c    = CNT_W'(DEPTH) - count_q;
    mem_ready = (free_c >= CNT_W'(1));
    alu_ready = mem_valid ? (free_c >= CNT_W'(2)) : (free_c >= CNT_W'(1));
  end

  // R0 results complete the handshake but never occupy an entry.
  assign mem_acc  = mem_valid && mem_ready;
  assign alu_acc  = alu_valid && alu_ready;
  assign mem_push = mem_acc && (mem_reg != '0);
  assign alu_push = alu_acc && (alu_reg != '0);

  // Write port drives straight from the head entry.
  assign pop        = !empty && !wb_stall;
  assign RegWriteEn = pop;
  assign WriteReg   = empty ? '0 : ent_reg_q[head_q];
  assign WriteData  = empty ? '0 : ent_data_q[head_q];

  // The load is the older instruction, so it takes the tail slot first.
  assign alu_slot = PTR_W'(tail_q + PTR_W'(mem_push));

  // Next-state for pointers, occupancy and valid bits
  always_comb begin
    head_d  = head_q;
    tail_d  = PTR_W'(tail_q + PTR_W'(mem_push) + PTR_W'(alu_push));
    count_d = CNT_W'(count_q + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop));
    vld_d   = vld_q;
    if (pop) begin
      head_d         = PTR_W'(head_q + PTR_W'(1));
      vld_d[head_q]  = 1'b0;
    end
    if (mem_push) begin
      vld_d[tail_q] = 1'b1;
    end
    if (alu_push) begin
      vld_d[alu_slot] = 1'b1;
    end
  end

  // slot_idx[k] is the physical slot k positions behind the head (k=0 oldest).
  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    assign slot_idx[g] = PTR_W'(head_q + PTR_W'(g));
  end

  // Lookup walks oldest to youngest so the last hit is the youngest value.
  always_comb begin
    look_busy1 = 1'b0;
    look_busy2 = 1'b0;
    look_data1 = '0;
    look_data2 = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (vld_q[slot_idx[k]] && (look_reg1 != '0) &&
          (ent_reg_q[slot_idx[k]] == look_reg1)) begin
        look_busy1 = 1'b1;
        look_data1 = ent_data_q[slot_idx[k]];
      end
      if (vld_q[slot_idx[k]] && (look_reg2 != '0) &&
          (ent_reg_q[slot_idx[k]] == look_reg2)) begin
        look_busy2 = 1'b1;
        look_data2 = ent_data_q[slot_idx[k]];
      end
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Entry storage; only the slots being pushed are written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_reg_q[i]  <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      if (mem_push) begin
        ent_reg_q[tail_q]  <= mem_reg;
        ent_data_q[tail_q] <= mem_data;
      end
      if (alu_push) begin
        ent_reg_q[alu_slot]  <= alu_reg;
        ent_data_q[alu_slot] <= alu_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue: stimulus pushes expected register
// file writes into a queue, a negedge monitor pops and compares every write.
module tb_reg_writeback_queue;

  logic       clk;
  logic       rst;
  logic       alu_valid;
  logic [2:0] alu_reg;
  logic [7:0] alu_data;
  logic       alu_ready;
  logic       mem_valid;
  logic [2:0] mem_reg;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic       wb_stall;
  logic       RegWriteEn;
  logic [2:0] WriteReg;
  logic [7:0] WriteData;
  logic [2:0] look_reg1;
  logic [2:0] look_reg2;
  logic       look_busy1;
  logic       look_busy2;
  logic [7:0] look_data1;
  logic [7:0] look_data2;
  logic [2:0] count;

  typedef struct packed {
    logic [2:0] r;
    logic [7:0] d;
  } wb_t;

  wb_t expq[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  reg_writeback_queue #(.DATA_W(8), .ADDR_W(3), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_reg   (alu_reg),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_reg   (mem_reg),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .wb_stall  (wb_stall),
    .RegWriteEn(RegWriteEn),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .look_reg1 (look_reg1),
    .look_reg2 (look_reg2),
    .look_busy1(look_busy1),
    .look_busy2(look_busy2),
    .look_data1(look_data1),
    .look_data2(look_data2),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; checks happen on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  // Monitor: every write the DUT commits must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && RegWriteEn) begin
      wb_t e;
      if (expq.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_write: got reg %0d data %0h expected none at %0t",
                 WriteReg, WriteData, $time);
      end else begin
        e = expq.pop_front();
        chk("wb_reg", 32'(WriteReg), 32'(e.r));
        chk("wb_data", 32'(WriteData), 32'(e.d));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b0;
    alu_valid = 1'b0;
    alu_reg   = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_reg   = '0;
    mem_data  = '0;
    wb_stall  = 1'b0;
    look_reg1 = 3'd3;
    look_reg2 = 3'd3;

    // Reset values
    cyc();
    mid();
    chk("rst_wen", 32'(RegWriteEn), 0);
    chk("rst_wreg", 32'(WriteReg), 0);
    chk("rst_wdata", 32'(WriteData), 0);
    chk("rst_busy1", 32'(look_busy1), 0);
    chk("rst_data2", 32'(look_data2), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_mem_ready", 32'(mem_ready), 1);
    chk("rst_alu_ready", 32'(alu_ready), 1);
    cyc();
    rst = 1'b1;

    // Single ALU result: visible next cycle, written, then gone
    cyc();
    alu_valid = 1'b1; alu_reg = 3'd3; alu_data = 8'h5A;
    expq.push_back('{r: 3'd3, d: 8'h5A});
    mid();
    chk("t1_alu_ready", 32'(alu_ready), 1);
    chk("t1_no_early_busy", 32'(look_busy1), 0);
    cyc();
    idle_inputs();
    mid();
    chk("t1_count1", 32'(count), 1);
    chk("t1_busy1", 32'(look_busy1), 1);
    chk("t1_data1", 32'(look_data1), 32'h5A);
    chk("t1_wen", 32'(RegWriteEn), 1);
    cyc();
    mid();
    chk("t1_count0", 32'(count), 0);
    chk("t1_busy1_clr", 32'(look_busy1), 0);

    // Same-cycle load and ALU to the same register
    cyc();
    look_reg2 = 3'd2;
    mem_valid = 1'b1; mem_reg = 3'd2; mem_data = 8'h11;
    alu_valid = 1'b1; alu_reg = 3'd2; alu_data = 8'h22;
    expq.push_back('{r: 3'd2, d: 8'h11});
    expq.push_back('{r: 3'd2, d: 8'h22});
    mid();
    chk("t2_mem_ready", 32'(mem_ready), 1);
    chk("t2_alu_ready", 32'(alu_ready), 1);
    cyc();
    idle_inputs();
    mid();
    chk("t2_count2", 32'(count), 2);
    chk("t2_busy2", 32'(look_busy2), 1);
    chk("t2_data2_both", 32'(look_data2), 32'h22);
    cyc();
    mid();
    chk("t2_count1", 32'(count), 1);
    chk("t2_data2_one", 32'(look_data2), 32'h22);
    cyc();
    mid();
    chk("t2_count0", 32'(count), 0);

    // Fill under stall, full handling, then drain in order
    for (int i = 1; i <= 4; i++) begin
      cyc();
      wb_stall  = 1'b1;
      alu_valid = 1'b1; alu_reg = 3'(i); alu_data = 8'(8'h30 + i);
      expq.push_back('{r: 3'(i), d: 8'(8'h30 + i)});
      mid();
      chk("t3_fill_ready", 32'(alu_ready), 1);
    end
    cyc();
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_reg = 3'd5; mem_data = 8'h99;
    mid();
    chk("t3_full_count", 32'(count), 4);
    chk("t3_full_alu_ready", 32'(alu_ready), 0);
    chk("t3_full_mem_ready", 32'(mem_ready), 0);
    chk("t3_stall_wen", 32'(RegWriteEn), 0);
    cyc();
    wb_stall = 1'b0;
    mid();
    chk("t3_full_pop_count", 32'(count), 4);
    chk("t3_full_pop_mem_ready", 32'(mem_ready), 0);
    chk("t3_full_pop_alu_ready", 32'(alu_ready), 0);
    chk("t3_pop_wen", 32'(RegWriteEn), 1);
    cyc();
    idle_inputs();
    mid();
    chk("t3_after_pop_count", 32'(count), 3);
    chk("t3_after_pop_mem_ready", 32'(mem_ready), 1);
    for (int i = 0; i < 3; i++) cyc();
    mid();
    chk("t3_drained", 32'(count), 0);

    // Three queued, both offered: only the load fits
    for (int i = 5; i <= 7; i++) begin
      cyc();
      wb_stall  = 1'b1;
      alu_valid = 1'b1; alu_reg = 3'(i); alu_data = 8'(8'h11 * i);
      expq.push_back('{r: 3'(i), d: 8'(8'h11 * i)});
    end
    cyc();
    mem_valid = 1'b1; mem_reg = 3'd1; mem_data = 8'hA1;
    alu_valid = 1'b1; alu_reg = 3'd2; alu_data = 8'hA2;
    expq.push_back('{r: 3'd1, d: 8'hA1});
    look_reg1 = 3'd7;
    mid();
    chk("t4_count3", 32'(count), 3);
    chk("t4_mem_ready", 32'(mem_ready), 1);
    chk("t4_alu_ready", 32'(alu_ready), 0);
    chk("t4_look7", 32'(look_data1), 32'h77);
    cyc();
    idle_inputs();
    mid();
    chk("t4_stalled_count", 32'(count), 4);
    chk("t4_alu_dropped", 32'(look_busy2), 0);
    cyc();
    wb_stall = 1'b0;
    cyc();
    mem_valid = 1'b1; mem_reg = 3'd3; mem_data = 8'hB3;
    alu_valid = 1'b1; alu_reg = 3'd4; alu_data = 8'hB4;
    expq.push_back('{r: 3'd3, d: 8'hB3});
    mid();
    chk("t4_pop_count3", 32'(count), 3);
    chk("t4_pop_mem_ready", 32'(mem_ready), 1);
    chk("t4_pop_alu_ready", 32'(alu_ready), 0);
    cyc();
    idle_inputs();
    mid();
    chk("t4_pop_count_kept", 32'(count), 3);
    for (int i = 0; i < 3; i++) cyc();
    mid();
    chk("t4_drained", 32'(count), 0);

    // Writes to R0 are accepted but never queued
    cyc();
    look_reg1 = 3'd0;
    alu_valid = 1'b1; alu_reg = 3'd0; alu_data = 8'hFF;
    mid();
    chk("t5_r0_ready", 32'(alu_ready), 1);
    cyc();
    idle_inputs();
    mid();
    chk("t5_r0_count", 32'(count), 0);
    chk("t5_r0_busy", 32'(look_busy1), 0);
    chk("t5_r0_data", 32'(look_data1), 0);
    chk("t5_r0_wen", 32'(RegWriteEn), 0);

    // Mid-cycle reset with three entries queued
    for (int i = 1; i <= 3; i++) begin
      cyc();
      wb_stall  = 1'b1;
      alu_valid = 1'b1; alu_reg = 3'(i); alu_data = 8'(8'hC0 + i);
      expq.push_back('{r: 3'(i), d: 8'(8'hC0 + i)});
    end
    cyc();
    idle_inputs();
    mid();
    chk("t6_pre_count", 32'(count), 3);
    cyc();
    #1;
    wb_stall = 1'b0;
    rst      = 1'b0;
    expq.delete();
    #1;
    chk("t6_async_count", 32'(count), 0);
    chk("t6_async_wen", 32'(RegWriteEn), 0);
    cyc();
    rst = 1'b1;
    mid();
    chk("t6_post_count", 32'(count), 0);
    chk("t6_post_wen", 32'(RegWriteEn), 0);
    chk("t6_post_mem_ready", 32'(mem_ready), 1);
    chk("t6_post_alu_ready", 32'(alu_ready), 1);
    for (int i = 0; i < 4; i++) cyc();
    mid();

    chk("sb_empty", 32'(expq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side companion of the 8-entry register file: buffers results from the ALU and data-memory paths and drives the register file write port (RegWriteEn/WriteReg/WriteData), one write per cycle.
- Provides a two-port pending-write lookup (busy flag plus youngest pending value) so decode can detect RAW hazards and forward data that is not yet in the register file.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 8, data width of every queued result.
- ADDR_W, 3, register address width (R0..R7).
- DEPTH, 4, queue entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result offered this cycle.
- alu_reg  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready.
- mem_valid  in  1  load result offered this cycle.
- mem_reg  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  load result accepted when mem_valid && mem_ready.
- wb_stall  in  1  hold the queue head; no write this cycle.
- RegWriteEn  out  1  register file write enable.
- WriteReg  out  ADDR_W  register file write address.
- WriteData  out  DATA_W  register file write data.
- look_reg1  in  ADDR_W  lookup address, port 1.
- look_reg2  in  ADDR_W  lookup address, port 2.
- look_busy1  out  1  look_reg1 has a queued write.
- look_busy2  out  1  look_reg2 has a queued write.
- look_data1  out  DATA_W  youngest queued value for look_reg1, else 0.
- look_data2  out  DATA_W  youngest queued value for look_reg2, else 0.
- count  out  clog2(DEPTH+1)  current number of occupied entries.

Behaviour:
- Storage is a circular FIFO with head pointer, tail pointer and count. On rst low, asynchronously: pointers=0, count=0, all entry valid bits=0.
- Reset outputs: RegWriteEn=0, WriteReg=0, WriteData=0, look_busy*=0, look_data*=0, count=0, mem_ready=1, alu_ready=1.
- Write port is combinational from the head:
  - RegWriteEn = (count!=0) && !wb_stall.
  - WriteReg and WriteData = head entry, or 0 when the queue is empty.
- Pop occurs at posedge when RegWriteEn=1. The register file commits that write on the same edge.
- Latency: a result accepted at edge N is at the head no earlier than after edge N, and is committed at edge N+1 at the earliest.
- Ready rules use count before any same-cycle pop; free = DEPTH - count:
  - mem_ready = (free >= 1).
  - alu_ready = (free >= 2) when mem_valid=1, otherwise (free >= 1).
- Simultaneous accepts: the mem entry is written at tail and the alu entry at tail+1, because the load belongs to the older instruction.
- Writes to R0 are handshaken (ready is honoured) but are not enqueued and do not change count.
- Push and pop in the same cycle are allowed. count update = count + pushes - pop. Pointers wrap modulo DEPTH.
- Full (count=DEPTH): both readies are 0, even if a pop happens that cycle. No overflow is possible.
- Empty: RegWriteEn=0 regardless of wb_stall.
- Lookup is combinational:
  - Searches all valid entries for a match, youngest first, including the head that is being written this cycle.
  - Offers presented in the current cycle are not visible until after the accepting edge.
  - A lookup of R0 always returns busy=0, data=0.
- Duplicate destinations in the queue are legal. Writes occur in FIFO order, and lookup returns the youngest matching value.
- Reset asserted mid-operation discards all queued entries. No write is issued for them.

Test Plan:
- Reset, then one cycle with alu_valid=1, alu_reg=3, alu_data=8'h5A -> next cycle RegWriteEn=1, WriteReg=3, WriteData=8'h5A, look_reg1=3 gives busy1=1 and data1=8'h5A; cycle after that count=0 and busy1=0.
- Same cycle mem(reg2,8'h11) and alu(reg2,8'h22) -> writes to reg2 of 8'h11 then 8'h22 on consecutive cycles; look_data for reg2 is 8'h22 while both are queued, then 8'h22 after the first pop.
- Hold wb_stall=1 and push 4 ALU results (regs 1-4) -> count=4, alu_ready=0 and mem_ready=0. Release the stall -> writes to regs 1,2,3,4 in order, and ready rises after the first pop.
- count=3 with mem_valid=1 and alu_valid=1 -> mem_ready=1, alu_ready=0. Only the mem entry is accepted; count=4 if stalled, or stays at 3 with a concurrent pop.
- alu_valid=1 with alu_reg=0 and data 8'hFF -> accepted, count unchanged, RegWriteEn never asserted, look_busy for R0 is 0.
- With 3 entries queued, pull rst low between edges -> count=0 and RegWriteEn=0 immediately; after release, no stale writes appear and both readies are 1.
